// File: rtl/lsq_mem_issue.sv
// lsq_mem_issue
//   Memory-issue stage behind the load/store queue. Pops the LSQ head once
//   its operands are resolved and runs one data-memory access on a req/ack
//   handshake. Load data is formatted (lane shift, size mask, sign/zero
//   extend) and the completion is broadcast on the CDB (valid/ready). A
//   tag-match flush kills a captured load so that it never broadcasts.
//
//   state | meaning
//   IDLE  | waiting for a ready LSQ head; lsq_pop may fire
//   ISSUE | mem_req held with stable address/data until mem_ack
//   RESP  | cdb_valid held with stable tag/data/exc until cdb_ready
//
// Ports
//   clock, reset                     clock, async active-low reset
//   lsq_*                            LSQ head view and pop strobe
//   flushing_instr, instr_to_flush   single-tag flush
//   mem_*                            data-memory request/ack interface
//   cdb_*                            completion broadcast
//   busy                             high whenever state is not IDLE

module lsq_mem_issue #(
    parameter int TAG_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lsq_empty,
    input  logic [TAG_W-1:0]  lsq_head_instr,
    input  logic              lsq_head_ready,
    input  logic              lsq_head_is_store,
    input  logic [DATA_W-1:0] lsq_head_addr,
    input  logic [DATA_W-1:0] lsq_head_wdata,
    input  logic [1:0]        lsq_head_size,
    input  logic              lsq_head_signed,
    output logic              lsq_pop,
    input  logic              flushing_instr,
    input  logic [TAG_W-1:0]  instr_to_flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cdb_valid,
    input  logic              cdb_ready,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_exc,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [TAG_W-1:0]  tag_q;
    logic              store_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              exc_q;
    logic              killed_q;
    logic [DATA_W-1:0] result_q;

    logic head_flush;
    logic head_misaligned;
    logic cap_flush;
    logic pop;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the store data across all lanes places it correctly in
    // whichever lane(s) the byte enables select.
    function automatic logic [DATA_W-1:0] lane_data(input logic [DATA_W-1:0] wd,
                                                    input logic [1:0] sz);
        logic [DATA_W-1:0] d;
        case (sz)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] rd,
                                                   input logic [1:0] off,
                                                   input logic [1:0] sz,
                                                   input logic sg);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] r;
        sh = rd >> {off, 3'b000};
        case (sz)
            2'b00:   r = {{24{sg & sh[7]}}, sh[7:0]};
            2'b01:   r = {{16{sg & sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    assign head_flush      = flushing_instr && (instr_to_flush == lsq_head_instr);
    assign head_misaligned = misaligned(lsq_head_size, lsq_head_addr[1:0]);
    // Stores only reach the head after commit, so they can never be squashed.
    assign cap_flush       = flushing_instr && (instr_to_flush == tag_q) && !store_q;
    assign pop             = (state == S_IDLE) && !lsq_empty && lsq_head_ready && !head_flush;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = head_misaligned ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    state_nxt = (killed_q || cap_flush) ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                // A flush beats a simultaneous cdb_ready; either way we leave.
                if (cap_flush || cdb_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Captured operation and load result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_q    <= '0;
            store_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= 2'b00;
            sgn_q    <= 1'b0;
            exc_q    <= 1'b0;
            killed_q <= 1'b0;
            result_q <= '0;
        end else begin
            if (pop) begin
                tag_q    <= lsq_head_instr;
                store_q  <= lsq_head_is_store;
                addr_q   <= lsq_head_addr;
                wdata_q  <= lsq_head_wdata;
                size_q   <= lsq_head_size;
                sgn_q    <= lsq_head_signed;
                exc_q    <= head_misaligned;
                killed_q <= 1'b0;
                result_q <= '0;
            end else if (state == S_ISSUE) begin
                if (cap_flush) begin
                    killed_q <= 1'b1;
                end
                if (mem_ack && !store_q) begin
                    result_q <= load_fmt(mem_rdata, addr_q[1:0], size_q, sgn_q);
                end
            end
        end
    end

    // Outputs: everything is zero outside the state that owns it.
    always_comb begin
        lsq_pop   = pop;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        cdb_exc   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = {addr_q[DATA_W-1:2], 2'b00};
                mem_wdata = lane_data(wdata_q, size_q);
                mem_be    = byte_en(size_q, addr_q[1:0]);
            end
            S_RESP: begin
                cdb_valid = 1'b1;
                cdb_tag   = tag_q;
                cdb_data  = exc_q ? '0 : result_q;
                cdb_exc   = exc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsq_mem_issue.sv
module tb_lsq_mem_issue;

    logic        clock;
    logic        reset;
    logic        lsq_empty;
    logic [31:0] lsq_head_instr;
    logic        lsq_head_ready;
    logic        lsq_head_is_store;
    logic [31:0] lsq_head_addr;
    logic [31:0] lsq_head_wdata;
    logic [1:0]  lsq_head_size;
    logic        lsq_head_signed;
    logic        lsq_pop;
    logic        flushing_instr;
    logic [31:0] instr_to_flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        cdb_valid;
    logic        cdb_ready;
    logic [31:0] cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_exc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    lsq_mem_issue #(.TAG_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .lsq_empty(lsq_empty), .lsq_head_instr(lsq_head_instr),
        .lsq_head_ready(lsq_head_ready), .lsq_head_is_store(lsq_head_is_store),
        .lsq_head_addr(lsq_head_addr), .lsq_head_wdata(lsq_head_wdata),
        .lsq_head_size(lsq_head_size), .lsq_head_signed(lsq_head_signed),
        .lsq_pop(lsq_pop),
        .flushing_instr(flushing_instr), .instr_to_flush(instr_to_flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_exc(cdb_exc), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit m_exc(input logic [31:0] a, input logic [1:0] sz);
        int off;
        off = a % 4;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (off % 2) != 0) return 1'b1;
        if (sz == 2'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        int off;
        off = a % 4;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_lane(input logic [31:0] w, input logic [1:0] sz);
        if (sz == 2'd0) return (w % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
        longint v;
        v = longint'(rd / (32'd1 << (8 * (a % 4))));
        if (sz == 2'd0) begin
            v = v % 256;
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    // ---------------- generic single-operation driver ----------------
    task automatic run_op(input logic [31:0] tag, input logic st, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] sz, input logic sg,
                          input logic [31:0] rd, input int ack_dly, input int rdy_dly,
                          input bit fl);
        bit          exc;
        logic [31:0] res;
        exc = m_exc(addr, sz);
        res = (st || exc) ? 32'd0 : m_load(rd, addr, sz, sg);

        @(negedge clock);
        lsq_empty = 1'b0; lsq_head_ready = 1'b1; lsq_head_instr = tag;
        lsq_head_is_store = st; lsq_head_addr = addr; lsq_head_wdata = wdata;
        lsq_head_size = sz; lsq_head_signed = sg; mem_ack = 1'b0; cdb_ready = 1'b0;
        #1;
        checks++; if (lsq_pop !== 1'b1) begin errors++; $display("FAIL pop_idle: got %b expected 1", lsq_pop); end
        @(negedge clock);
        lsq_empty = 1'b1; lsq_head_ready = 1'b0;

        if (exc) begin
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL exc_no_req: got %b expected 0", mem_req); end
            checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL exc_valid: got %b expected 1", cdb_valid); end
        end else begin
            for (int n = 0; n <= ack_dly; n++) begin
                if (n > 0) begin
                    @(negedge clock);
                    flushing_instr = 1'b0;
                end
                checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mem_req: got %b expected 1", mem_req); end
                checks++; if (mem_we !== st) begin errors++; $display("FAIL mem_we: got %b expected %b", mem_we, st); end
                checks++; if (mem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL mem_addr: got %h expected %h", mem_addr, {addr[31:2], 2'b00}); end
                checks++; if (mem_be !== m_be(addr, sz)) begin errors++; $display("FAIL mem_be: got %b expected %b", mem_be, m_be(addr, sz)); end
                if (st) begin
                    checks++; if (mem_wdata !== m_lane(wdata, sz)) begin errors++; $display("FAIL mem_wdata: got %h expected %h", mem_wdata, m_lane(wdata, sz)); end
                end
                checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL valid_in_issue: got %b expected 0", cdb_valid); end
                if (n == 0 && fl) begin
                    flushing_instr = 1'b1; instr_to_flush = tag;
                end
            end
            mem_ack = 1'b1; mem_rdata = rd;
            @(negedge clock);
            mem_ack = 1'b0; mem_rdata = $urandom; flushing_instr = 1'b0;
            if (fl && !st) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL killed_busy: got %b expected 0", busy); end
                checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL killed_valid: got %b expected 0", cdb_valid); end
                return;
            end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL req_after_ack: got %b expected 0", mem_req); end
        end

        lsq_empty = 1'b0; lsq_head_ready = 1'b1; lsq_head_instr = tag + 1;
        for (int n = 0; n <= rdy_dly; n++) begin
            if (n > 0) @(negedge clock);
            #1;
            checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL cdb_valid: got %b expected 1", cdb_valid); end
            checks++; if (cdb_tag !== tag) begin errors++; $display("FAIL cdb_tag: got %h expected %h", cdb_tag, tag); end
            checks++; if (cdb_data !== res) begin errors++; $display("FAIL cdb_data: got %h expected %h", cdb_data, res); end
            checks++; if (cdb_exc !== exc) begin errors++; $display("FAIL cdb_exc: got %b expected %b", cdb_exc, exc); end
            checks++; if (lsq_pop !== 1'b0) begin errors++; $display("FAIL pop_in_resp: got %b expected 0", lsq_pop); end
        end
        lsq_empty = 1'b1; lsq_head_ready = 1'b0; cdb_ready = 1'b1;
        @(negedge clock);
        cdb_ready = 1'b0;
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL valid_after_accept: got %b expected 0", cdb_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_accept: got %b expected 0", busy); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0)
            begin errors++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h be=%b expected all 0", mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
        checks++; if (cdb_valid !== 1'b0 || cdb_tag !== 32'd0 || cdb_data !== 32'd0 || cdb_exc !== 1'b0)
            begin errors++; $display("FAIL reset_cdb: got v=%b tag=%h data=%h exc=%b expected all 0", cdb_valid, cdb_tag, cdb_data, cdb_exc); end
        checks++; if (busy !== 1'b0 || lsq_pop !== 1'b0) begin errors++; $display("FAIL reset_busy_pop: got busy=%b pop=%b expected 0", busy, lsq_pop); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_word_load();
        run_op(32'd5, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0, 32'hDEAD_BEEF, 3, 0, 1'b0);
    endtask

    task automatic test_byte_load();
        run_op(32'd6, 1'b0, 32'h103, 32'd0, 2'b00, 1'b1, 32'h80FF_FF11, 1, 1, 1'b0);
        run_op(32'd7, 1'b0, 32'h103, 32'd0, 2'b00, 1'b0, 32'h80FF_FF11, 0, 0, 1'b0);
    endtask

    task automatic test_half_store();
        run_op(32'd8, 1'b1, 32'h202, 32'h0000_1234, 2'b01, 1'b0, 32'hFFFF_FFFF, 2, 0, 1'b0);
    endtask

    task automatic test_misaligned();
        run_op(32'd10, 1'b0, 32'h101, 32'd0, 2'b10, 1'b0, 32'd0, 0, 4, 1'b0);
        run_op(32'd11, 1'b1, 32'h40, 32'd1, 2'b11, 1'b0, 32'd0, 0, 0, 1'b0);
    endtask

    task automatic test_flush_issue();
        run_op(32'd9, 1'b0, 32'h300, 32'd0, 2'b10, 1'b0, 32'h1234_5678, 2, 0, 1'b1);
        // flush of a captured store tag is ignored
        run_op(32'd12, 1'b1, 32'h304, 32'hAABB_CCDD, 2'b10, 1'b0, 32'd0, 2, 0, 1'b1);
    endtask

    task automatic test_flush_head_idle();
        @(negedge clock);
        lsq_empty = 1'b0; lsq_head_ready = 1'b1; lsq_head_instr = 32'd13;
        lsq_head_addr = 32'h0; lsq_head_size = 2'b10; lsq_head_is_store = 1'b0;
        flushing_instr = 1'b1; instr_to_flush = 32'd13;
        #1;
        checks++; if (lsq_pop !== 1'b0) begin errors++; $display("FAIL pop_flush_head: got %b expected 0", lsq_pop); end
        instr_to_flush = 32'd14;
        #1;
        checks++; if (lsq_pop !== 1'b1) begin errors++; $display("FAIL pop_flush_other: got %b expected 1", lsq_pop); end
        instr_to_flush = 32'd13;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_head_busy: got %b expected 0", busy); end
        lsq_empty = 1'b1; lsq_head_ready = 1'b0; flushing_instr = 1'b0;
    endtask

    task automatic test_flush_resp();
        @(negedge clock);
        lsq_empty = 1'b0; lsq_head_ready = 1'b1; lsq_head_instr = 32'h21;
        lsq_head_addr = 32'h200; lsq_head_size = 2'b10; lsq_head_is_store = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clock);
        lsq_empty = 1'b1; lsq_head_ready = 1'b0;
        @(negedge clock);
        mem_ack = 1'b0;
        flushing_instr = 1'b1; instr_to_flush = 32'h22;
        @(negedge clock);
        checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL resp_other_flush: got v=%b data=%h expected 1 0badf00d", cdb_valid, cdb_data); end
        instr_to_flush = 32'h21; cdb_ready = 1'b1;
        @(negedge clock);
        flushing_instr = 1'b0; cdb_ready = 1'b0;
        checks++; if (cdb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL resp_flush: got v=%b busy=%b expected 0 0", cdb_valid, busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        lsq_empty = 1'b0; lsq_head_ready = 1'b1; lsq_head_instr = 32'h30;
        lsq_head_addr = 32'h400; lsq_head_size = 2'b10; lsq_head_is_store = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222; cdb_ready = 1'b1;
        #1;
        checks++; if (lsq_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop_c0: got %b expected 1", lsq_pop); end
        @(negedge clock);
        lsq_head_instr = 32'h31;
        #1;
        checks++; if (mem_req !== 1'b1 || lsq_pop !== 1'b0) begin errors++; $display("FAIL b2b_c1: got req=%b pop=%b expected 1 0", mem_req, lsq_pop); end
        @(negedge clock);
        #1;
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 32'h30 || lsq_pop !== 1'b0) begin errors++; $display("FAIL b2b_c2: got v=%b tag=%h pop=%b expected 1 30 0", cdb_valid, cdb_tag, lsq_pop); end
        @(negedge clock);
        #1;
        checks++; if (cdb_valid !== 1'b0 || lsq_pop !== 1'b1) begin errors++; $display("FAIL b2b_c3: got v=%b pop=%b expected 0 1", cdb_valid, lsq_pop); end
        @(negedge clock);
        lsq_empty = 1'b1; lsq_head_ready = 1'b0;
        @(negedge clock);
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 32'h31) begin errors++; $display("FAIL b2b_second: got v=%b tag=%h expected 1 31", cdb_valid, cdb_tag); end
        @(negedge clock);
        mem_ack = 1'b0; cdb_ready = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_in_issue();
        @(negedge clock);
        lsq_empty = 1'b0; lsq_head_ready = 1'b1; lsq_head_instr = 32'h40;
        lsq_head_addr = 32'h500; lsq_head_size = 2'b10; lsq_head_is_store = 1'b1;
        lsq_head_wdata = 32'hCAFE_0001;
        @(negedge clock);
        lsq_empty = 1'b1; lsq_head_ready = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_issue_req: got %b expected 1", mem_req); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_be !== 4'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL rst_issue_drop: got req=%b we=%b addr=%h be=%b busy=%b expected all 0", mem_req, mem_we, mem_addr, mem_be, busy); end
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++; if (busy !== 1'b0 || cdb_valid !== 1'b0 || cdb_tag !== 32'd0 || cdb_data !== 32'd0 || mem_wdata !== 32'd0)
            begin errors++; $display("FAIL rst_late_ack: got busy=%b v=%b tag=%h data=%h wdata=%h expected all 0", busy, cdb_valid, cdb_tag, cdb_data, mem_wdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0] sz;
            logic [31:0] a;
            int ad;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            ad = $urandom_range(0, 3);
            run_op($urandom, 1'($urandom_range(0, 1)), a, $urandom, sz,
                   1'($urandom_range(0, 1)), $urandom, ad, $urandom_range(0, 3),
                   (ad > 0) && ($urandom_range(0, 4) == 0));
        end
    endtask

    initial begin
        reset = 1'b0; lsq_empty = 1'b1; lsq_head_instr = '0; lsq_head_ready = 1'b0;
        lsq_head_is_store = 1'b0; lsq_head_addr = '0; lsq_head_wdata = '0;
        lsq_head_size = 2'b00; lsq_head_signed = 1'b0; flushing_instr = 1'b0;
        instr_to_flush = '0; mem_ack = 1'b0; mem_rdata = '0; cdb_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_flush_issue();
        test_flush_head_idle();
        test_flush_resp();
        test_back_to_back();
        test_reset_in_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
